// File: rtl/timed_sram_pkg.sv
// Shared types and default sizing for the timed SRAM model: FSM states,
// operation encoding and request decoding.
package timed_sram_pkg;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_ADDR_W      = 18;
    localparam int DEF_DEPTH       = 65536;
    localparam int DEF_WAIT_CYCLES = 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        READ,
        WRITE,
        ILLEGAL
    } op_t;

    // Enables are active-low; asserting both at once is an illegal request.
    function automatic op_t decodeOp(input logic oeN, input logic weN);
        if (!oeN && !weN) begin
            return ILLEGAL;
        end else if (!weN) begin
            return WRITE;
        end else begin
            return READ;
        end
    endfunction

endpackage

// File: rtl/sram_array.sv
// Plain DEPTH x DATA_W storage with a byte-enabled synchronous write port
// and a synchronous read port; all sequencing lives in the parent.
module sram_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 65536,
    parameter int IDX_W  = 16
) (
    input  logic                  clk,
    input  logic                  wrEn,
    input  logic [IDX_W-1:0]      wrAddr,
    input  logic [DATA_W-1:0]     wrData,
    input  logic [DATA_W/8-1:0]   wrBeN,
    input  logic [IDX_W-1:0]      rdAddr,
    output logic [DATA_W-1:0]     rdData
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (!wrBeN[i]) begin
                    mem[wrAddr][i*8 +: 8] <= wrData[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        rdData <= mem[rdAddr];
    end

endmodule

// File: rtl/timed_sram_model.sv
// Fixed-latency SRAM model: samples one request in IDLE, waits WAIT_CYCLES
// in BUSY, performs the access, then pulses ramReady for one DONE cycle.
module timed_sram_model
    import timed_sram_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ramEN,
    input  logic                  ramOE,
    input  logic                  ramWE,
    input  logic [ADDR_W-1:0]     ramAddr,
    input  logic [DATA_W-1:0]     ramInputData,
    input  logic [DATA_W/8-1:0]   ramBE_n,
    output logic [DATA_W-1:0]     ramOutputData,
    output logic                  ramReady,
    output logic                  ramErr
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);

    state_t               state;
    op_t                  latOp;
    logic [3:0]           waitCnt;
    logic [IDX_W-1:0]     latIdx;
    logic [DATA_W-1:0]    latData;
    logic [DATA_W/8-1:0]  latBeN;
    logic                 latInRange;

    logic                 reqValid;
    logic                 inRangeNow;
    logic                 accessNow;
    logic                 arrWrEn;
    logic [IDX_W-1:0]     arrRdAddr;
    logic [DATA_W-1:0]    arrRdData;

    assign reqValid   = !ramEN && (!ramOE || !ramWE);
    assign inRangeNow = {1'b0, ramAddr} < DEPTH_LIM;
    assign accessNow  = (state == BUSY) && (waitCnt == 4'd0);
    // Gated by rst so a reset landing on the access edge still drops the write.
    assign arrWrEn    = rst && accessNow && (latOp == WRITE) && latInRange;
    // Read the live address on the sampling edge so data is ready even with no wait states.
    assign arrRdAddr  = (state == IDLE) ? ramAddr[IDX_W-1:0] : latIdx;

    sram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk    (clk),
        .wrEn   (arrWrEn),
        .wrAddr (latIdx),
        .wrData (latData),
        .wrBeN  (latBeN),
        .rdAddr (arrRdAddr),
        .rdData (arrRdData)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            waitCnt       <= 4'd0;
            ramReady      <= 1'b0;
            ramErr        <= 1'b0;
            ramOutputData <= '0;
        end else begin
            ramReady <= 1'b0;
            ramErr   <= 1'b0;
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        latOp      <= decodeOp(ramOE, ramWE);
                        latIdx     <= ramAddr[IDX_W-1:0];
                        latData    <= ramInputData;
                        latBeN     <= ramBE_n;
                        latInRange <= inRangeNow;
                        waitCnt    <= WAIT_INIT;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (waitCnt != 4'd0) begin
                        waitCnt <= waitCnt - 4'd1;
                    end else begin
                        state    <= DONE;
                        ramReady <= 1'b1;
                        ramErr   <= (latOp == ILLEGAL) || !latInRange;
                        if (latOp == READ) begin
                            ramOutputData <= latInRange ? arrRdData : '0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timed_sram_model.sv
// Directed bench for timed_sram_model: four instances (defaults, and DEPTH=1024
// with 0, 4 and 3 wait states) share one input bus; each test checks one instance.
module tb_timed_sram_model;

    logic        clk = 1'b0;
    logic        rst;
    logic        ramEN;
    logic        ramOE;
    logic        ramWE;
    logic [17:0] ramAddr;
    logic [15:0] ramInputData;
    logic [1:0]  ramBE_n;

    logic [15:0] outData [4];
    logic        readyV  [4];
    logic        errV    [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    timed_sram_model u_def (
        .clk(clk), .rst(rst), .ramEN(ramEN), .ramOE(ramOE), .ramWE(ramWE),
        .ramAddr(ramAddr), .ramInputData(ramInputData), .ramBE_n(ramBE_n),
        .ramOutputData(outData[0]), .ramReady(readyV[0]), .ramErr(errV[0])
    );

    timed_sram_model #(.DEPTH(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .ramEN(ramEN), .ramOE(ramOE), .ramWE(ramWE),
        .ramAddr(ramAddr), .ramInputData(ramInputData), .ramBE_n(ramBE_n),
        .ramOutputData(outData[1]), .ramReady(readyV[1]), .ramErr(errV[1])
    );

    timed_sram_model #(.DEPTH(1024), .WAIT_CYCLES(4)) u_w4 (
        .clk(clk), .rst(rst), .ramEN(ramEN), .ramOE(ramOE), .ramWE(ramWE),
        .ramAddr(ramAddr), .ramInputData(ramInputData), .ramBE_n(ramBE_n),
        .ramOutputData(outData[2]), .ramReady(readyV[2]), .ramErr(errV[2])
    );

    timed_sram_model #(.DEPTH(1024), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .ramEN(ramEN), .ramOE(ramOE), .ramWE(ramWE),
        .ramAddr(ramAddr), .ramInputData(ramInputData), .ramBE_n(ramBE_n),
        .ramOutputData(outData[3]), .ramReady(readyV[3]), .ramErr(errV[3])
    );

    // One request, then the bus is scrambled while the instance is busy; edges counts the sampling edge as 1.
    task automatic applyStimulus(input int d, input logic oeN, input logic weN,
                                 input logic [17:0] addr, input logic [15:0] data,
                                 input logic [1:0] beN, output int edges,
                                 output logic [15:0] rdata, output logic err);
        repeat (8) @(posedge clk);
        @(negedge clk);
        ramEN = 1'b0; ramOE = oeN; ramWE = weN;
        ramAddr = addr; ramInputData = data; ramBE_n = beN;
        @(posedge clk); #1;
        edges = 1;
        ramEN = 1'b1; ramOE = 1'b1; ramWE = 1'b1;
        ramAddr = ~addr; ramInputData = ~data; ramBE_n = 2'b00;
        while (!readyV[d] && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        rdata = outData[d];
        err   = errV[d];
        if (!readyV[d]) begin
            total++; bad++;
            $display("[TB] FAIL timeout dut%0d addr=%h: no ramReady within %0d edges", d, addr, edges);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ramEN = 1'b0; ramOE = 1'b1; ramWE = 1'b0;
        ramAddr = 18'h00010; ramInputData = 16'h9999; ramBE_n = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            total++;
            if (readyV[d] !== 1'b0 || errV[d] !== 1'b0 || outData[d] !== 16'h0000) begin
                bad++;
                $display("[TB] FAIL reset_outputs dut%0d: got rdy=%b err=%b data=%h, want 0 0 0000",
                         d, readyV[d], errV[d], outData[d]);
            end
        end
        @(negedge clk);
        ramEN = 1'b1; ramOE = 1'b1; ramWE = 1'b1;
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            total++;
            if (readyV[0] !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_request_ignored cycle %0d: got rdy=%b, want 0", c, readyV[0]);
            end
        end
    endtask

    task automatic test_write_read();
        int edges; logic [15:0] rd; logic err;
        applyStimulus(0, 1'b1, 1'b0, 18'h00010, 16'h1234, 2'b00, edges, rd, err);
        total++;
        if (edges !== 3) begin bad++; $display("[TB] FAIL wr_latency: got %0d edges, want 3", edges); end
        total++;
        if (err !== 1'b0) begin bad++; $display("[TB] FAIL wr_err: got %b, want 0", err); end
        @(posedge clk); #1;
        total++;
        if (readyV[0] !== 1'b0) begin bad++; $display("[TB] FAIL ready_one_cycle: got %b, want 0", readyV[0]); end
        applyStimulus(0, 1'b0, 1'b1, 18'h00010, 16'h0000, 2'b11, edges, rd, err);
        total++;
        if (edges !== 3) begin bad++; $display("[TB] FAIL rd_latency: got %0d edges, want 3", edges); end
        total++;
        if (rd !== 16'h1234) begin bad++; $display("[TB] FAIL rd_data: got %h, want 1234", rd); end
        total++;
        if (err !== 1'b0) begin bad++; $display("[TB] FAIL rd_err: got %b, want 0", err); end
        repeat (3) @(posedge clk); #1;
        total++;
        if (outData[0] !== 16'h1234) begin bad++; $display("[TB] FAIL rd_hold: got %h, want 1234", outData[0]); end
    endtask

    task automatic test_byte_enable();
        int edges; logic [15:0] rd; logic err;
        applyStimulus(0, 1'b1, 1'b0, 18'h00005, 16'hAAAA, 2'b00, edges, rd, err);
        applyStimulus(0, 1'b1, 1'b0, 18'h00005, 16'h5566, 2'b10, edges, rd, err);
        applyStimulus(0, 1'b0, 1'b1, 18'h00005, 16'h0000, 2'b00, edges, rd, err);
        total++;
        if (rd !== 16'hAA66) begin bad++; $display("[TB] FAIL be_low_byte: got %h, want aa66", rd); end
        applyStimulus(0, 1'b1, 1'b0, 18'h00005, 16'h7788, 2'b01, edges, rd, err);
        applyStimulus(0, 1'b0, 1'b1, 18'h00005, 16'h0000, 2'b11, edges, rd, err);
        total++;
        if (rd !== 16'h7766) begin bad++; $display("[TB] FAIL be_high_byte: got %h, want 7766", rd); end
    endtask

    task automatic test_range_illegal();
        int edges; logic [15:0] rd; logic err;
        applyStimulus(1, 1'b1, 1'b0, 18'h00000, 16'h1357, 2'b00, edges, rd, err);
        applyStimulus(1, 1'b1, 1'b0, 18'h00400, 16'hFFFF, 2'b00, edges, rd, err);
        total++;
        if (err !== 1'b1) begin bad++; $display("[TB] FAIL oor_wr_err: got %b, want 1", err); end
        applyStimulus(1, 1'b0, 1'b1, 18'h00400, 16'h0000, 2'b00, edges, rd, err);
        total++;
        if (err !== 1'b1) begin bad++; $display("[TB] FAIL oor_rd_err: got %b, want 1", err); end
        total++;
        if (rd !== 16'h0000) begin bad++; $display("[TB] FAIL oor_rd_data: got %h, want 0000", rd); end
        applyStimulus(1, 1'b1, 1'b0, 18'h10400, 16'hEEEE, 2'b00, edges, rd, err);
        total++;
        if (err !== 1'b1) begin bad++; $display("[TB] FAIL fullwidth_err: got %b, want 1", err); end
        applyStimulus(1, 1'b1, 1'b0, 18'h003FF, 16'h2468, 2'b00, edges, rd, err);
        total++;
        if (err !== 1'b0) begin bad++; $display("[TB] FAIL last_word_err: got %b, want 0", err); end
        applyStimulus(1, 1'b0, 1'b1, 18'h00000, 16'h0000, 2'b00, edges, rd, err);
        total++;
        if (rd !== 16'h1357 || err !== 1'b0) begin
            bad++; $display("[TB] FAIL word0_kept: got %h err=%b, want 1357 err=0", rd, err);
        end
        applyStimulus(1, 1'b0, 1'b0, 18'h00000, 16'hDEAD, 2'b00, edges, rd, err);
        total++;
        if (err !== 1'b1) begin bad++; $display("[TB] FAIL illegal_err: got %b, want 1", err); end
        total++;
        if (rd !== 16'h1357) begin bad++; $display("[TB] FAIL illegal_out_held: got %h, want 1357", rd); end
        applyStimulus(1, 1'b0, 1'b1, 18'h00000, 16'h0000, 2'b00, edges, rd, err);
        total++;
        if (rd !== 16'h1357) begin bad++; $display("[TB] FAIL illegal_mem_kept: got %h, want 1357", rd); end
        applyStimulus(1, 1'b0, 1'b1, 18'h003FF, 16'h0000, 2'b00, edges, rd, err);
        total++;
        if (rd !== 16'h2468) begin bad++; $display("[TB] FAIL last_word_data: got %h, want 2468", rd); end
    endtask

    task automatic test_wait_states();
        int edges; logic [15:0] rd; logic err;
        applyStimulus(1, 1'b1, 1'b0, 18'h00003, 16'h4321, 2'b00, edges, rd, err);
        total++;
        if (edges !== 2) begin bad++; $display("[TB] FAIL w0_latency: got %0d edges, want 2", edges); end
        applyStimulus(1, 1'b0, 1'b1, 18'h00003, 16'h0000, 2'b00, edges, rd, err);
        total++;
        if (rd !== 16'h4321) begin bad++; $display("[TB] FAIL w0_data: got %h, want 4321", rd); end
        applyStimulus(2, 1'b1, 1'b0, 18'h00003, 16'h4444, 2'b00, edges, rd, err);
        total++;
        if (edges !== 6) begin bad++; $display("[TB] FAIL w4_latency: got %0d edges, want 6", edges); end
        applyStimulus(2, 1'b0, 1'b1, 18'h00003, 16'h0000, 2'b00, edges, rd, err);
        total++;
        if (edges !== 6) begin bad++; $display("[TB] FAIL w4_rd_latency: got %0d edges, want 6", edges); end
        total++;
        if (rd !== 16'h4444 || err !== 1'b0) begin
            bad++; $display("[TB] FAIL w4_data: got %h err=%b, want 4444 err=0", rd, err);
        end
    endtask

    task automatic test_back_to_back();
        int n; int m;
        repeat (8) @(posedge clk);
        @(negedge clk);
        ramEN = 1'b0; ramOE = 1'b0; ramWE = 1'b1;
        ramAddr = 18'h00010; ramBE_n = 2'b00;
        n = 0;
        while (!readyV[0] && n < 20) begin @(posedge clk); #1; n++; end
        m = 0;
        do begin @(posedge clk); #1; m++; end while (!readyV[0] && m < 20);
        ramEN = 1'b1; ramOE = 1'b1;
        total++;
        if (m !== 4) begin bad++; $display("[TB] FAIL b2b_period: got %0d cycles, want 4", m); end
        total++;
        if (outData[0] !== 16'h1234) begin bad++; $display("[TB] FAIL b2b_data: got %h, want 1234", outData[0]); end
    endtask

    task automatic test_reset_mid_op();
        int edges; int readies; logic [15:0] rd; logic err;
        applyStimulus(3, 1'b1, 1'b0, 18'h00007, 16'h1111, 2'b00, edges, rd, err);
        repeat (8) @(posedge clk);
        @(negedge clk);
        ramEN = 1'b0; ramOE = 1'b1; ramWE = 1'b0;
        ramAddr = 18'h00007; ramInputData = 16'hBEEF; ramBE_n = 2'b00;
        @(posedge clk); #1;
        ramEN = 1'b1; ramWE = 1'b1;
        readies = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (readyV[3] !== 1'b0 || errV[3] !== 1'b0 || outData[3] !== 16'h0000) begin
            bad++; $display("[TB] FAIL mid_reset_outputs: got rdy=%b err=%b data=%h, want 0 0 0000",
                            readyV[3], errV[3], outData[3]);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (readyV[3] === 1'b1) readies++;
        end
        total++;
        if (readies !== 0) begin bad++; $display("[TB] FAIL aborted_no_ready: got %0d pulses, want 0", readies); end
        applyStimulus(3, 1'b0, 1'b1, 18'h00007, 16'h0000, 2'b00, edges, rd, err);
        total++;
        if (rd !== 16'h1111) begin bad++; $display("[TB] FAIL aborted_write_dropped: got %h, want 1111", rd); end
        total++;
        if (edges !== 5) begin bad++; $display("[TB] FAIL w3_latency: got %0d edges, want 5", edges); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_range_illegal();
        test_wait_states();
        test_back_to_back();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
